// File: rtl/regfile_arbiter.sv
// Round-robin arbiter and sequencer for two requesters sharing one
// single-port 8x16 register file; serialises commands and returns read data.
module regfile_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  wr0,
    input  logic                  wr1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  done0,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] WrData,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic                  WrEn,
    output logic                  RdEn,
    input  logic [DATA_WIDTH-1:0] RdData
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    last_q, last_d;
    logic                    cmd_wr_q, cmd_wr_d;
    logic                    gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                    done0_q, done0_d, done1_q, done1_d;
    logic                    busy_q, busy_d;
    logic                    wren_q, wren_d, rden_q, rden_d;
    logic [ADDR_WIDTH-1:0]   address_q, address_d;
    logic [DATA_WIDTH-1:0]   wrdata_q, wrdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    winner;
    logic                    win_wr;

    // Requester 1 wins when it is alone, or on a tie when requester 0 went last.
    assign winner = req1 & (~req0 | ~last_q);
    assign win_wr = winner ? wr1 : wr0;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cmd_wr_d  = cmd_wr_q;
        gnt0_d    = gnt0_q;
        gnt1_d    = gnt1_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        busy_d    = busy_q;
        wren_d    = 1'b0;
        rden_d    = 1'b0;
        address_d = address_q;
        wrdata_d  = wrdata_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d   = ISSUE;
                    last_d    = winner;
                    gnt0_d    = ~winner;
                    gnt1_d    = winner;
                    busy_d    = 1'b1;
                    cmd_wr_d  = win_wr;
                    address_d = winner ? addr1 : addr0;
                    wrdata_d  = winner ? wdata1 : wdata0;
                    wren_d    = win_wr;
                    rden_d    = ~win_wr;
                end
            end
            ISSUE: begin
                if (cmd_wr_q) begin
                    state_d = DONE;
                    done0_d = gnt0_q;
                    done1_d = gnt1_q;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                state_d = DONE;
                rdata_d = RdData;
                done0_d = gnt0_q;
                done1_d = gnt1_q;
            end
            DONE: begin
                state_d   = IDLE;
                gnt0_d    = 1'b0;
                gnt1_d    = 1'b0;
                busy_d    = 1'b0;
                cmd_wr_d  = 1'b0;
                address_d = '0;
                wrdata_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            cmd_wr_q  <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            busy_q    <= 1'b0;
            wren_q    <= 1'b0;
            rden_q    <= 1'b0;
            address_q <= '0;
            wrdata_q  <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cmd_wr_q  <= cmd_wr_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            busy_q    <= busy_d;
            wren_q    <= wren_d;
            rden_q    <= rden_d;
            address_q <= address_d;
            wrdata_q  <= wrdata_d;
            rdata_q   <= rdata_d;
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign done0   = done0_q;
    assign done1   = done1_q;
    assign busy    = busy_q;
    assign WrEn    = wren_q;
    assign RdEn    = rden_q;
    assign Address = address_q;
    assign WrData  = wrdata_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural 8x16 register file
// (synchronous write, registered read) attached to its port.
module tb_regfile_arbiter;
  logic        CLK, RST;
  logic        req0, req1, wr0, wr1;
  logic [2:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, busy, WrEn, RdEn;
  logic [15:0] rdata, WrData, RdData;
  logic [2:0]  Address;

  int n_vec = 0;
  int n_err = 0;
  logic en_both_seen = 0;
  logic gnt_both_seen = 0;
  logic [15:0] mem [8];
  logic [0:0]  exp_q[$];
  logic [31:0] exp_cyc_q[$];

  regfile_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
    .CLK(CLK), .RST(RST),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .busy(busy),
    .WrData(WrData), .Address(Address), .WrEn(WrEn), .RdEn(RdEn),
    .RdData(RdData)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    RdData = 16'h0000;
  end

  always @(posedge CLK) begin
    if (WrEn) mem[Address] <= WrData;
    if (RdEn) RdData <= mem[Address];
  end

  always @(negedge CLK) begin
    if (WrEn && RdEn) en_both_seen = 1'b1;
    if (gnt0 && gnt1) gnt_both_seen = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int side, input logic r, input logic w,
                         input logic [2:0] a, input logic [15:0] d);
    if (side == 0) begin
      req0 = r; wr0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; wr1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    step();
    step();
    RST = 1'b0;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ctl"}, {25'd0, gnt0, gnt1, done0, done1, busy, WrEn, RdEn}, 32'd0);
    check({tag, "_address"}, {29'd0, Address}, 32'd0);
    check({tag, "_wrdata"}, {16'd0, WrData}, 32'd0);
    check({tag, "_rdata"}, {16'd0, rdata}, 32'd0);
  endtask

  task automatic single_txn(input string tag, input int side, input logic w,
                            input logic [2:0] a, input logic [15:0] d,
                            input logic [15:0] exp_rd);
    int cyc = 0;
    int en_pulses = 0;
    logic other_seen = 1'b0;
    logic done_seen = 1'b0;
    logic gnt_at_done = 1'b0;
    set_req(side, 1, w, a, d);
    while (!done_seen && cyc < 20) begin
      step();
      cyc++;
      if (w ? WrEn : RdEn) en_pulses++;
      if (w ? RdEn : WrEn) en_pulses += 100;
      if (side == 0 ? (gnt1 | done1) : (gnt0 | done0)) other_seen = 1'b1;
      done_seen   = (side == 0) ? done0 : done1;
      gnt_at_done = (side == 0) ? gnt0 : gnt1;
    end
    check({tag, "_latency"}, cyc, w ? 32'd2 : 32'd3);
    check({tag, "_en_pulses"}, en_pulses, 32'd1);
    check({tag, "_other_idle"}, {31'd0, other_seen}, 32'd0);
    check({tag, "_gnt_held"}, {31'd0, gnt_at_done}, 32'd1);
    if (!w) check({tag, "_rdata"}, {16'd0, rdata}, {16'd0, exp_rd});
    set_req(side, 0, 0, 0, 0);
    step();
    check({tag, "_idle"}, {29'd0, busy, gnt0, gnt1}, 32'd0);
  endtask

  initial begin
    int cyc;
    int served0, served1;
    logic got_side;
    logic saw_done;

    RST = 1'b1;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    step();
    check_reset_outs("reset");
    step();
    RST = 1'b0;

    // unwritten register read by requester 1
    single_txn("unwritten", 1, 1'b0, 3'd5, 16'h0000, 16'h0000);

    // write then read back through requester 0
    single_txn("wr_abcd", 0, 1'b1, 3'd0, 16'hABCD, 16'h0000);
    check("wr_abcd_mem", {16'd0, mem[0]}, 32'h0000ABCD);
    single_txn("rd_abcd", 0, 1'b0, 3'd0, 16'h0000, 16'hABCD);

    // tie after reset: requester 0 first
    apply_reset();
    set_req(0, 1, 1, 3'd1, 16'h1111);
    set_req(1, 1, 1, 3'd2, 16'h2222);
    exp_q = {1'b0, 1'b1};
    exp_cyc_q = {32'd2, 32'd5};
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 30) begin
      step();
      cyc++;
      if (done0 | done1) begin
        got_side = done1;
        check("tie_order", {31'd0, got_side}, {31'd0, exp_q.pop_front()});
        check("tie_done_cyc", cyc, exp_cyc_q.pop_front());
        if (done0) set_req(0, 0, 0, 0, 0);
        if (done1) set_req(1, 0, 0, 0, 0);
      end
    end
    check("tie_complete", exp_q.size(), 32'd0);
    step();

    // fairness: six back-to-back reads, both sides continuously requesting
    set_req(0, 1, 0, 3'd1, 16'h0000);
    set_req(1, 1, 0, 3'd2, 16'h0000);
    exp_q = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_cyc_q = {32'd3, 32'd7, 32'd11, 32'd15, 32'd19, 32'd23};
    served0 = 0;
    served1 = 0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 60) begin
      step();
      cyc++;
      if (done0 | done1) begin
        got_side = done1;
        check("fair_order", {31'd0, got_side}, {31'd0, exp_q.pop_front()});
        check("fair_done_cyc", cyc, exp_cyc_q.pop_front());
        check("fair_rdata", {16'd0, rdata}, done1 ? 32'h2222 : 32'h1111);
        if (done0) begin
          served0++;
          if (served0 == 3) set_req(0, 0, 0, 0, 0);
        end
        if (done1) begin
          served1++;
          if (served1 == 3) set_req(1, 0, 0, 0, 0);
        end
      end
    end
    check("fair_complete", exp_q.size(), 32'd0);
    step();

    // reset during WAIT abandons the read
    set_req(0, 1, 0, 3'd0, 16'h0000);
    step();
    check("rst_issue_rden", {31'd0, RdEn}, 32'd1);
    step();
    check("rst_wait_busy", {30'd0, busy, gnt0}, 32'd3);
    RST = 1'b1;
    set_req(0, 0, 0, 0, 0);
    step();
    check_reset_outs("rst_mid");
    RST = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done0 | done1) saw_done = 1'b1;
    end
    check("rst_no_done", {31'd0, saw_done}, 32'd0);
    single_txn("rst_recover", 1, 1'b0, 3'd0, 16'h0000, 16'hABCD);

    // non-preemption: requester 1 arrives during requester 0's ISSUE
    set_req(0, 1, 1, 3'd3, 16'h3333);
    step();
    check("np_issue_wren", {30'd0, WrEn, gnt0}, 32'd3);
    set_req(1, 1, 0, 3'd3, 16'h0000);
    step();
    check("np_done0", {30'd0, done0, gnt1}, 32'd2);
    set_req(0, 0, 0, 0, 0);
    step();
    check("np_idle_gap", {30'd0, gnt1, busy}, 32'd0);
    step();
    check("np_gnt1_rise", {30'd0, gnt1, RdEn}, 32'd3);
    cyc = 4;
    while (!done1 && cyc < 20) begin
      step();
      cyc++;
    end
    check("np_done1_cyc", cyc, 32'd6);
    check("np_rdata", {16'd0, rdata}, 32'h3333);
    set_req(1, 0, 0, 0, 0);
    step();

    // rdata survives a write
    single_txn("wr_keep", 0, 1'b1, 3'd7, 16'h7777, 16'h0000);
    check("wr_keep_rdata", {16'd0, rdata}, 32'h3333);
    single_txn("rd_addr7", 1, 1'b0, 3'd7, 16'h0000, 16'h7777);

    check("en_exclusive", {31'd0, en_both_seen}, 32'd0);
    check("gnt_exclusive", {31'd0, gnt_both_seen}, 32'd0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
